// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush and x0 write suppression.
// Optional stall counter enabled by defining MEM_WB_PERF_EN.
module mem_wb_pipe_reg #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [LANES*XLEN-1:0]   mem_data,
  input  logic [LANES*5-1:0]      mem_rd,
  input  logic [LANES-1:0]        mem_we,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [LANES*XLEN-1:0]   wb_data,
  output logic [LANES*5-1:0]      wb_rd,
  output logic [LANES-1:0]        wb_we
`ifdef MEM_WB_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt
`endif
);

  localparam int unsigned DW = LANES * XLEN;
  localparam int unsigned RW = LANES * 5;

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [RW-1:0]    rd;
    logic [LANES-1:0] we;
  } bundle_t;

  bundle_t          in_b;
  bundle_t          out_q, out_n;
  bundle_t          skid_q, skid_n;
  logic             out_valid_q, out_valid_n;
  logic             skid_valid_q, skid_valid_n;
  logic             ready_q;
  logic [LANES-1:0] we_q;
  logic             accept;
  logic             drain;

  assign accept = mem_valid & ready_q;
  assign drain  = out_valid_q & wb_ready;

  // Incoming bundle with writes to x0 suppressed per lane
  always_comb begin
    in_b.data = mem_data;
    in_b.rd   = mem_rd;
    in_b.we   = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      in_b.we[i] = mem_we[i] & (mem_rd[i*5 +: 5] != 5'd0);
    end
  end

  // Next state of output and skid entries; skid can only fill while mem_ready is high
  always_comb begin
    out_valid_n  = out_valid_q;
    out_n        = out_q;
    skid_valid_n = skid_valid_q;
    skid_n       = skid_q;
    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end else if (out_valid_q && !drain) begin
      if (accept) begin
        skid_valid_n = 1'b1;
        skid_n       = in_b;
      end
    end else if (skid_valid_q) begin
      out_valid_n  = 1'b1;
      out_n        = skid_q;
      skid_valid_n = 1'b0;
    end else if (accept) begin
      out_valid_n = 1'b1;
      out_n       = in_b;
    end else begin
      out_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      ready_q      <= 1'b0;
      we_q         <= '0;
    end else begin
      out_valid_q  <= out_valid_n;
      out_q        <= out_n;
      skid_valid_q <= skid_valid_n;
      skid_q       <= skid_n;
      ready_q      <= !skid_valid_n;
      we_q         <= out_valid_n ? out_n.we : '0;
    end
  end

  assign mem_ready = ready_q;
  assign wb_valid  = out_valid_q;
  assign wb_data   = out_q.data;
  assign wb_rd     = out_q.rd;
  assign wb_we     = we_q;

`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating back-pressure counter, survives flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (out_valid_q && !wb_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

  // An upstream presenting data while the skid is full would lose it
  mem_valid_ignores_ready: assert property (
    @(posedge clk) disable iff (!rst_n) (mem_valid && !flush) |-> ready_q
  );

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg (LANES=2, CNT_W=2); stall counter checks need MEM_WB_PERF_EN.
module tb_mem_wb_pipe_reg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned LANES = 2;
  localparam int unsigned CNT_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [LANES*XLEN-1:0] mem_data;
  logic [LANES*5-1:0]    mem_rd;
  logic [LANES-1:0]      mem_we;
  logic                  wb_valid;
  logic                  wb_ready;
  logic [LANES*XLEN-1:0] wb_data;
  logic [LANES*5-1:0]    wb_rd;
  logic [LANES-1:0]      wb_we;
`ifdef MEM_WB_PERF_EN
  logic [CNT_W-1:0]      stall_cnt;
`endif

  mem_wb_pipe_reg #(.XLEN(XLEN), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_data(mem_data), .mem_rd(mem_rd), .mem_we(mem_we),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we)
`ifdef MEM_WB_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*XLEN-1:0] data;
    logic [LANES*5-1:0]    rd;
    logic [LANES-1:0]      we;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_on = 1'b0;
  logic exp_ready = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d1, input logic [31:0] d0,
                       input logic [4:0] r1, input logic [4:0] r0, input logic [1:0] we);
    mem_valid = 1'b1;
    mem_data  = {d1, d0};
    mem_rd    = {r1, r0};
    mem_we    = we;
  endtask

  // Reference occupancy/ordering model evaluated mid-cycle for the upcoming edge
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      chk("mon_valid", 64'(wb_valid), 64'(q.size() != 0));
      chk("mon_ready", 64'(mem_ready), 64'(exp_ready));
      if (!wb_valid) chk("mon_we_idle", 64'(wb_we), 64'(0));
      if (!rst_n) begin
        q.delete();
        exp_ready = 1'b0;
      end else begin
        if (wb_valid && wb_ready) begin
          if (q.size() == 0) begin
            chk("mon_underflow", 64'(1), 64'(0));
          end else begin
            e = q.pop_front();
            chk("sb_data", 64'(wb_data), 64'(e.data));
            chk("sb_rd", 64'(wb_rd), 64'(e.rd));
            chk("sb_we", 64'(wb_we), 64'(e.we));
          end
        end
        if (flush) begin
          q.delete();
        end else if (mem_valid && mem_ready) begin
          e.data = mem_data;
          e.rd   = mem_rd;
          for (int i = 0; i < int'(LANES); i++) begin
            e.we[i] = mem_we[i] && (mem_rd[i*5 +: 5] != 5'd0);
          end
          q.push_back(e);
        end
        exp_ready = (q.size() < 2);
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    drive(32'h22, 32'h11, 5'd5, 5'd3, 2'b11);

    // Reset held for 3 cycles with mem_valid asserted
    for (int i = 0; i < 3; i++) begin
      step();
      mon_on = 1'b1;
      chk("rst_valid", 64'(wb_valid), 64'(0));
      chk("rst_we", 64'(wb_we), 64'(0));
      chk("rst_ready", 64'(mem_ready), 64'(0));
    end
    rst_n = 1'b1; mem_valid = 1'b0;
    step();
    chk("rst_ready_after", 64'(mem_ready), 64'(1));
    chk("rst_data", 64'(wb_data), 64'(0));

    // Streaming A then B with no bubbles
    drive(32'h22, 32'h11, 5'd5, 5'd3, 2'b11);
    step();
    drive(32'h44, 32'h33, 5'd9, 5'd7, 2'b11);
    chk("stream_a_valid", 64'(wb_valid), 64'(1));
    chk("stream_a_data", 64'(wb_data), 64'h0000_0022_0000_0011);
    chk("stream_a_rd", 64'(wb_rd), 64'({5'd5, 5'd3}));
    step();
    mem_valid = 1'b0;
    chk("stream_b_valid", 64'(wb_valid), 64'(1));
    chk("stream_b_data", 64'(wb_data), 64'h0000_0044_0000_0033);
    chk("stream_b_rd", 64'(wb_rd), 64'({5'd9, 5'd7}));
    step();
    chk("stream_idle", 64'(wb_valid), 64'(0));
    chk("stream_hold", 64'(wb_data), 64'h0000_0044_0000_0033);

    // Back-pressure fills the skid, then drains in order
    wb_ready = 1'b0;
    drive(32'h22, 32'h11, 5'd5, 5'd3, 2'b11);
    step();
    drive(32'h44, 32'h33, 5'd9, 5'd7, 2'b11);
    chk("bp_ready_1", 64'(mem_ready), 64'(1));
    step();
    mem_valid = 1'b0;
    chk("bp_ready_full", 64'(mem_ready), 64'(0));
    chk("bp_hold_a", 64'(wb_data), 64'h0000_0022_0000_0011);
    step();
    chk("bp_still_a", 64'(wb_data), 64'h0000_0022_0000_0011);
    wb_ready = 1'b1;
    step();
    chk("bp_b_next", 64'(wb_data), 64'h0000_0044_0000_0033);
    chk("bp_ready_back", 64'(mem_ready), 64'(1));
    step();
    chk("bp_empty", 64'(wb_valid), 64'(0));

    // x0 lane write suppression
    drive(32'hBB, 32'hAA, 5'd4, 5'd0, 2'b11);
    step();
    mem_valid = 1'b0;
    chk("x0_we", 64'(wb_we), 64'(2'b10));
    step();
    chk("x0_idle_we", 64'(wb_we), 64'(0));

    // Flush with both entries full and an incoming bundle C
    wb_ready = 1'b0;
    drive(32'h22, 32'h11, 5'd5, 5'd3, 2'b11);
    step();
    drive(32'h44, 32'h33, 5'd9, 5'd7, 2'b11);
    step();
    drive(32'h66, 32'h55, 5'd2, 5'd1, 2'b11);
    flush = 1'b1;
    step();
    flush = 1'b0; mem_valid = 1'b0;
    chk("flush_valid", 64'(wb_valid), 64'(0));
    chk("flush_ready", 64'(mem_ready), 64'(1));
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("flush_no_c", 64'(wb_valid), 64'(0));
    end

    // Random traffic against the scoreboard
    for (int n = 0; n < 300; n++) begin
      wb_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 19) == 0);
      if (mem_ready && ($urandom_range(0, 3) != 0)) begin
        drive($urandom, $urandom, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              2'($urandom_range(0, 3)));
      end else begin
        mem_valid = 1'b0;
      end
      step();
    end
    flush = 1'b0; mem_valid = 1'b0; wb_ready = 1'b1;
    repeat (4) step();
    chk("rand_drained", 64'(q.size()), 64'(0));

`ifdef MEM_WB_PERF_EN
    // Saturating stall counter: flush keeps it, reset clears it
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("perf_clear", 64'(stall_cnt), 64'(0));
    wb_ready = 1'b0;
    drive(32'h22, 32'h11, 5'd5, 5'd3, 2'b11);
    step();
    mem_valid = 1'b0;
    repeat (5) step();
    chk("perf_sat", 64'(stall_cnt), 64'(3));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("perf_flush", 64'(stall_cnt), 64'(3));
    rst_n = 1'b0;
    step();
    chk("perf_reset", 64'(stall_cnt), 64'(0));
    rst_n = 1'b1;
    wb_ready = 1'b1;
    step();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
